// File: rtl/apb_slave.sv
// APB slave front-end over a 16 x 32-bit register memory (instance `mem`).
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states per transfer.

module apb_slave_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_rnw_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic [DATA_W-1:0] req_rdata_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the array is small and must read back as zero after reset, so every
  // word is cleared explicitly; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
    end else if (req_valid_i && !req_rnw_i) begin
      mem[req_addr_i] <= req_wdata_i;
    end
  end

  assign req_rdata_o = mem[req_addr_i];

endmodule

module apb_slave #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              cnt_zero;
  logic              read_load;
  logic              complete;

`ifdef APB_WAIT_STATE_EN
  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == SETUP && psel_i && penable_i) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if (state_q == ACCESS && !psel_i) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign cnt_zero  = (cnt_q == '0);
  // Read data is captured on the last wait edge so it is valid while pready_o is high.
  assign read_load = (state_q == ACCESS) && psel_i && (cnt_q == 4'd1) && !write_q;
`else
  // WAIT_CYCLES has no effect in the zero-wait build.
  logic unused_wait;
  assign unused_wait = ^WAIT_CYCLES;
  assign cnt_zero    = 1'b1;
  assign read_load   = (state_q == SETUP) && psel_i && penable_i && !pwrite_i;
`endif

  assign complete = (state_q == ACCESS) && cnt_zero && psel_i && penable_i;

  // The SETUP->ACCESS capture needs the address the master is presenting now,
  // since addr_q only picks it up at that same edge.
  assign mem_addr = (state_q == SETUP) ? paddr_i : addr_q;

  apb_slave_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) mem (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (complete),
    .req_rnw_i   (!write_q),
    .req_addr_i  (mem_addr),
    .req_wdata_i (wdata_q),
    .req_rdata_o (mem_rdata)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // state_d unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (psel_i && !penable_i) state_d = SETUP;
      SETUP: begin
        if (!psel_i)        state_d = IDLE;
        else if (penable_i) state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel_i)       state_d = IDLE;
        else if (complete) state_d = DONE;
      end
      DONE: begin
        if (!psel_i)         state_d = IDLE;
        else if (!penable_i) state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SETUP) begin
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
      end
      if (read_load) prdata_q <= mem_rdata;
    end
  end

  assign prdata_o = prdata_q;
  assign pready_o = (state_q != ACCESS) || cnt_zero;

endmodule

// File: tb/tb_apb_slave.sv
// Directed + random bench for apb_slave; read expectations flow through a scoreboard queue.
module tb_apb_slave;

  localparam int WAIT_EXP =
`ifdef APB_WAIT_STATE_EN
    2;
`else
    0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [16];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  apb_slave #(.ADDR_W(4), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .psel_i    (psel),
    .penable_i (penable),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  // Full transfer; hold > 0 keeps psel/penable high that many cycles after completion.
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d, input int hold);
    int          n;
    logic [31:0] rd_before;
    rd_before = prdata;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    if (!wr) exp_q.push_back(model[a]);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    n = 0;
    while (pready !== 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("wait_states", 32'(n), 32'(WAIT_EXP));
    if (wr) check("mem_before_commit", dut.mem.mem[a], model[a]);
    else    check("read_data", prdata, exp_q.pop_front());
    if (wr) model[a] = d;
    @(negedge clk);
    if (wr) begin
      check("mem_after_commit", dut.mem.mem[a], model[a]);
      check("write_keeps_prdata", prdata, rd_before);
    end
    rd_before = prdata;
    for (int i = 0; i < hold; i++) begin
      pwdata = 32'h0;
      check("done_pready", 32'(pready), 32'd1);
      @(negedge clk);
      check("done_no_rewrite", dut.mem.mem[a], model[a]);
      check("done_prdata", prdata, rd_before);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [3:0]  ra;
    logic [31:0] rdv;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

    // Reset state
    do_reset(2);
    check("reset_pready", 32'(pready), 32'd1);
    check("reset_prdata", prdata, 32'h0);
    for (int i = 0; i < 16; i++) check("reset_mem", dut.mem.mem[i], 32'h0);

    // Write 0x5 then read it back; other words stay zero
    xfer(1'b1, 4'h5, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 4'h5, 32'h0, 0);
    for (int i = 0; i < 16; i++) if (i != 5) check("others_zero", dut.mem.mem[i], 32'h0);

    // Write 0xA with 5-cycle hold after completion and pwdata changed to 0
    xfer(1'b1, 4'hA, 32'h1234_5678, 5);
    xfer(1'b0, 4'hA, 32'h0, 0);

    // psel+penable from IDLE without a SETUP phase must be ignored
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'h9; pwdata = 32'hBAD0_0009;
    repeat (3) @(negedge clk);
    check("no_setup_pready", 32'(pready), 32'd1);
    check("no_setup_mem", dut.mem.mem[9], 32'h0);
    psel = 1'b0; penable = 1'b0;

    // Abort a write to 0x3: drop psel in a wait state (or in SETUP when zero-wait)
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h3; pwdata = 32'hCAFE_0003;
    @(negedge clk);
    if (WAIT_EXP > 0) begin
      penable = 1'b1;
      @(negedge clk);
      check("abort_wait_pready", 32'(pready), 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pready", 32'(pready), 32'd1);
    check("abort_mem", dut.mem.mem[3], 32'h0);
    xfer(1'b1, 4'h3, 32'h0000_3333, 0);
    xfer(1'b0, 4'h3, 32'h0, 0);

    // Reset in the middle of a write to 0x7
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h7; pwdata = 32'h7777_7777;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    check("midreset_mem7", dut.mem.mem[7], 32'h0);
    check("midreset_mem5", dut.mem.mem[5], 32'h0);
    check("midreset_prdata", prdata, 32'h0);
    check("midreset_pready", 32'(pready), 32'd1);
    xfer(1'b1, 4'h7, 32'h0000_0707, 0);
    xfer(1'b0, 4'h7, 32'h0, 0);

    // Random fill then full read-back through the scoreboard
    for (int i = 0; i < 16; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rdv = $urandom;
      xfer(1'b1, ra, rdv, 0);
    end
    for (int i = 0; i < 16; i++) xfer(1'b0, 4'(i), 32'h0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
